// File: rtl/seq_detect_ctrl_if.sv
// seq_detect_ctrl_if: command, detector-link and result signals of the 1011 job sequencer
interface seq_detect_ctrl_if #(parameter int DATA_W = 16, parameter int CNT_W = 5);
  logic              start;
  logic              abort;
  logic [DATA_W-1:0] data_in;
  logic              busy;
  logic              det_rst;
  logic              ser_out;
  logic              ser_valid;
  logic              det_y;
  logic [CNT_W-1:0]  match_cnt;
  logic [CNT_W-1:0]  first_pos;
  logic              found;
  logic              done;
  modport master (output start, abort, data_in, det_y,
                  input busy, det_rst, ser_out, ser_valid, match_cnt, first_pos, found, done);
  modport slave  (input start, abort, data_in, det_y,
                  output busy, det_rst, ser_out, ser_valid, match_cnt, first_pos, found, done);
endinterface

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: serializes a captured word into an external Moore 1011 detector and tallies its matches
module seq_detect_ctrl #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
) (
  input logic              clk,
  input logic              rst,
  seq_detect_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_t;
  state_t state, nxt;
  logic [DATA_W-1:0] sreg;
  logic [CNT_W-1:0] idx, cnt, first, pos;
  logic fnd, abort_pend, run, kill, accept, last, hit;
  assign run    = state == CLR || state == SHIFT || state == DRAIN;
  assign kill   = run && bus.abort;
  assign accept = state == IDLE && bus.start && !bus.abort;
  assign last   = idx == CNT_W'(DATA_W - 1);
  // the detector's Moore output lags one cycle, so SHIFT i reports bit i-1 and DRAIN reports the last bit
  assign hit    = bus.det_y && ((state == SHIFT && idx != '0) || state == DRAIN);
  assign pos    = state == DRAIN ? CNT_W'(DATA_W - 1) : idx - 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = accept ? CLR : IDLE;
      CLR:     nxt = kill ? IDLE : SHIFT;
      SHIFT:   nxt = kill ? IDLE : last ? DRAIN : SHIFT;
      DRAIN:   nxt = kill ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sreg       <= '0;
      idx        <= '0;
      cnt        <= '0;
      first      <= '0;
      fnd        <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      abort_pend <= kill;
      if (accept) begin
        sreg  <= bus.data_in;
        idx   <= '0;
        cnt   <= '0;
        first <= '0;
        fnd   <= 1'b0;
      end else if (kill) begin
        cnt   <= '0;
        first <= '0;
        fnd   <= 1'b0;
      end else begin
        if (state == SHIFT) begin
          sreg <= sreg << 1;
          idx  <= idx + 1'b1;
        end
        if (hit) begin
          cnt <= cnt == '1 ? cnt : cnt + 1'b1;
          if (!fnd) begin
            fnd   <= 1'b1;
            first <= pos;
          end
        end
      end
    end
  assign bus.busy      = state != IDLE;
  assign bus.det_rst   = state == CLR || abort_pend;
  assign bus.ser_valid = state == SHIFT;
  assign bus.ser_out   = state == SHIFT && sreg[DATA_W-1];
  assign bus.done      = state == DONE;
  assign bus.match_cnt = cnt;
  assign bus.first_pos = first;
  assign bus.found     = fnd;
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl: scoreboard bench with a behavioural 1011 detector and a word-level match model
module tb_seq_detect_ctrl;
  localparam int DW = 16;
  localparam int CW = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  seq_detect_ctrl_if #(.DATA_W(DW), .CNT_W(CW)) bus ();
  seq_detect_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [3:0] hist;
  always @(posedge clk or posedge rst)
    if (rst) hist <= 4'h0;
    else if (bus.det_rst) hist <= 4'h0;
    else if (bus.ser_valid) hist <= {hist[2:0], bus.ser_out};
  assign bus.det_y = hist == 4'b1011;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {int cnt; int first; int fnd; int t;} exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0d want %0d (t=%0t)", name, act, req, $time);
    end
  endtask
  function automatic void model(input logic [DW-1:0] d, output exp_t e);
    e.cnt = 0; e.first = 0; e.fnd = 0;
    for (int p = 3; p < DW; p++)
      if (((d >> (DW - 1 - p)) & 16'hF) == 16'hB) begin
        if (e.cnt == 0) e.first = p;
        e.cnt++;
        e.fnd = 1;
      end
    if (e.cnt > (1 << CW) - 1) e.cnt = (1 << CW) - 1;
  endfunction
  always @(posedge clk) begin
    #1;
    if (!rst && bus.done) begin
      if (q.size() == 0) chk("spurious_done", int'(bus.done), 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("match_cnt", int'(bus.match_cnt), e.cnt);
        chk("first_pos", int'(bus.first_pos), e.first);
        chk("found", int'(bus.found), e.fnd);
        chk("done_latency", cyc - e.t, DW + 3);
      end
    end
  end
  task automatic job(input logic [DW-1:0] d, input bit expect_done);
    exp_t e;
    @(negedge clk);
    bus.data_in = d;
    bus.start   = 1'b1;
    if (expect_done) begin
      model(d, e);
      e.t = cyc;
      q.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", int'(bus.busy), 0);
  endtask
  task automatic outputs_zero(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_det_rst"}, int'(bus.det_rst), 0);
    chk({tag, "_ser_valid"}, int'(bus.ser_valid), 0);
    chk({tag, "_ser_out"}, int'(bus.ser_out), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_found"}, int'(bus.found), 0);
    chk({tag, "_match_cnt"}, int'(bus.match_cnt), 0);
    chk({tag, "_first_pos"}, int'(bus.first_pos), 0);
  endtask
  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    logic [DW-1:0] d;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.data_in = '0;
    repeat (2) @(negedge clk);
    outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    job(16'hB6D8, 1'b1);
    wait_idle();
    chk("hold_match_cnt", int'(bus.match_cnt), 4);
    chk("hold_first_pos", int'(bus.first_pos), 3);
    job(16'hBBBB, 1'b1);
    wait_idle();
    job(16'hFFFF, 1'b1);
    wait_idle();
    job(16'h0000, 1'b1);
    wait_idle();
    job(16'hB6D8, 1'b1);
    repeat (6) @(negedge clk);
    bus.start = 1'b1;
    bus.data_in = 16'hBBBB;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    job(16'hB6D8, 1'b0);
    repeat (9) @(negedge clk);
    chk("pre_abort_busy", int'(bus.busy), 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_det_rst", int'(bus.det_rst), 1);
    chk("abort_match_cnt", int'(bus.match_cnt), 0);
    chk("abort_found", int'(bus.found), 0);
    chk("abort_done", int'(bus.done), 0);
    @(negedge clk);
    chk("abort_det_rst_once", int'(bus.det_rst), 0);
    job(16'hBBBB, 1'b1);
    wait_idle();
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort_idle", int'(bus.busy), 0);
    job(16'hB6D8, 1'b1);
    repeat (11) @(negedge clk);
    #2 rst = 1'b1;
    #1 outputs_zero("async_rst");
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    job(16'hB6D8, 1'b1);
    wait_idle();
    repeat (20) begin
      d = DW'($urandom);
      job(d, 1'b1);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 12)) @(negedge clk);
        bus.start = 1'b1;
        bus.data_in = DW'($urandom);
        @(negedge clk);
        bus.start = 1'b0;
      end
      wait_idle();
    end
    repeat (3) @(negedge clk);
    chk("pending_jobs", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
